// File: rtl/crc_engine.sv
// crc_engine: parameterised CRC-32 engine, DW bits per cycle, with
// frame check (residue compare) and FCS serialisation.
//
// Ports:
//   clk        rising-edge clock
//   res        asynchronous active-low reset
//   start      preset the register and open a frame (highest priority)
//   din_vld    din valid this cycle (accepted only in ACC)
//   din        DW-bit data word
//   din_last   with din_vld: final word of the frame
//   fcs_req    serialise the FCS (accepted in ACC without din_vld, or DONE)
//   dout       FCS word, valid with dout_vld
//   dout_vld   high for each EMIT cycle
//   dout_last  high with the final FCS word
//   crc        XOROUT ^ (REFOUT ? bitrev32(reg) : reg), combinational
//   crc_done   one-cycle pulse after the last word is accepted
//   crc_ok     register matched RESIDUE after the last word; held to start
//   busy       state is not IDLE
module crc_engine #(
    parameter int          DW      = 4,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter bit          REFIN   = 1'b1,
    parameter bit          REFOUT  = 1'b1,
    parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          din_vld,
    input  logic [DW-1:0] din,
    input  logic          din_last,
    input  logic          fcs_req,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          dout_last,
    output logic [31:0]   crc,
    output logic          crc_done,
    output logic          crc_ok,
    output logic          busy
);

    localparam int         NW   = 32 / DW;
    localparam logic [3:0] LAST = 4'(NW - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE,
        EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;

    logic [DW-1:0] w;
    logic [31:0]   upd;
    logic [DW-1:0] top;

    function automatic logic [DW-1:0] rev_dw(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) begin
            r[i] = v[DW-1-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // MSB-first: the highest word bit meets the register first.
    function automatic logic [31:0] crc_step(
        input logic [31:0]   c_in,
        input logic [DW-1:0] d
    );
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    always_comb begin
        w   = REFIN ? rev_dw(din) : din;
        upd = crc_step(acc_q, w);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        if (start) begin
            state_d = ACC;
            acc_d   = INIT;
            cnt_d   = '0;
            ok_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ACC: begin
                    if (din_vld) begin
                        acc_d = upd;
                        if (din_last) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            ok_d    = (upd == RESIDUE);
                        end
                    end else if (fcs_req) begin
                        state_d = EMIT;
                    end
                end
                DONE: begin
                    if (fcs_req) begin
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    // Shift the emitted word out, filling with ones so the
                    // register ends at all-ones after the last word.
                    acc_d = {acc_q[31-DW:0], {DW{1'b1}}};
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            acc_q   <= INIT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    // Outputs decode from flops only, so reset clears them at once.
    always_comb begin
        top       = acc_q[31:32-DW];
        dout      = '0;
        dout_vld  = 1'b0;
        dout_last = 1'b0;
        if (state_q == EMIT) begin
            dout      = REFIN ? rev_dw(~top) : ~top;
            dout_vld  = 1'b1;
            dout_last = (cnt_q == LAST);
        end
        crc      = XOROUT ^ (REFOUT ? rev32(acc_q) : acc_q);
        crc_done = done_q;
        crc_ok   = ok_q;
        busy     = (state_q != IDLE);
    end

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: drives DW=8 and DW=4 instances of crc_engine and checks
// them against a reflected, LSB-first CRC-32 reference model.
module tb_crc_engine;

    logic clk;
    logic res;

    logic       s8_start, s8_vld, s8_last, s8_fcs;
    logic [7:0] s8_din;
    logic [7:0] o8_dout;
    logic       o8_dvld, o8_dlast, o8_done, o8_ok, o8_busy;
    logic [31:0] o8_crc;

    logic       s4_start, s4_vld, s4_last, s4_fcs;
    logic [3:0] s4_din;
    logic [3:0] o4_dout;
    logic       o4_dvld, o4_dlast, o4_done, o4_ok, o4_busy;
    logic [31:0] o4_crc;

    int total = 0;
    int bad   = 0;

    logic [7:0] fr[$];

    crc_engine #(.DW(8)) dut8 (
        .clk(clk), .res(res), .start(s8_start), .din_vld(s8_vld),
        .din(s8_din), .din_last(s8_last), .fcs_req(s8_fcs),
        .dout(o8_dout), .dout_vld(o8_dvld), .dout_last(o8_dlast),
        .crc(o8_crc), .crc_done(o8_done), .crc_ok(o8_ok), .busy(o8_busy)
    );

    crc_engine #(.DW(4)) dut4 (
        .clk(clk), .res(res), .start(s4_start), .din_vld(s4_vld),
        .din(s4_din), .din_last(s4_last), .fcs_req(s4_fcs),
        .dout(o4_dout), .dout_vld(o4_dvld), .dout_last(o4_dlast),
        .crc(o4_crc), .crc_done(o4_done), .crc_ok(o4_ok), .busy(o4_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reflected CRC-32 register over fr, bit by bit, LSB first.
    function automatic logic [31:0] model_r();
        logic [31:0] r;
        logic [7:0]  b;
        r = 32'hFFFFFFFF;
        foreach (fr[i]) begin
            b = fr[i];
            for (int k = 0; k < 8; k++) begin
                if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
                else             r = r >> 1;
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed8(input bit gaps);
        s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        foreach (fr[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            s8_vld  = 1'b1;
            s8_din  = fr[i];
            s8_last = (i == fr.size() - 1);
            step();
            s8_vld  = 1'b0;
            s8_last = 1'b0;
        end
    endtask

    task automatic feed4(input bit gaps);
        logic [7:0] b;
        s4_start = 1'b1;
        step();
        s4_start = 1'b0;
        foreach (fr[i]) begin
            b = fr[i];
            for (int h = 0; h < 2; h++) begin
                if (gaps) repeat ($urandom_range(0, 2)) step();
                s4_vld  = 1'b1;
                s4_din  = (h == 0) ? b[3:0] : b[7:4];
                s4_last = (i == fr.size() - 1) && (h == 1);
                step();
                s4_vld  = 1'b0;
                s4_last = 1'b0;
            end
        end
    endtask

    task automatic emit8(input logic [31:0] exp);
        s8_fcs = 1'b1;
        step();
        s8_fcs = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (o8_dvld !== 1'b1 || o8_dout !== exp[8*k +: 8] ||
                o8_dlast !== (k == 3)) begin
                bad++;
                $display("FAIL emit8 word %0d: got vld=%b d=%h last=%b want d=%h",
                         k, o8_dvld, o8_dout, o8_dlast, exp[8*k +: 8]);
            end
            step();
        end
        total++;
        if (o8_busy !== 1'b0 || o8_dvld !== 1'b0) begin
            bad++;
            $display("FAIL emit8 end: got busy=%b vld=%b want 0 0",
                     o8_busy, o8_dvld);
        end
    endtask

    task automatic emit4(input logic [31:0] exp);
        s4_fcs = 1'b1;
        step();
        s4_fcs = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (o4_dvld !== 1'b1 || o4_dout !== exp[4*k +: 4] ||
                o4_dlast !== (k == 7)) begin
                bad++;
                $display("FAIL emit4 word %0d: got vld=%b d=%h last=%b want d=%h",
                         k, o4_dvld, o4_dout, o4_dlast, exp[4*k +: 4]);
            end
            step();
        end
        total++;
        if (o4_busy !== 1'b0 || o4_dvld !== 1'b0) begin
            bad++;
            $display("FAIL emit4 end: got busy=%b vld=%b want 0 0",
                     o4_busy, o4_dvld);
        end
    endtask

    task automatic load_check_string();
        fr.delete();
        for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    endtask

    task automatic test_reset();
        res = 1'b0;
        {s8_start, s8_vld, s8_last, s8_fcs} = '0;
        {s4_start, s4_vld, s4_last, s4_fcs} = '0;
        s8_din = '0;
        s4_din = '0;
        #12;
        total++;
        if ({o8_busy, o8_dvld, o8_dlast, o8_done, o8_ok, o8_dout} !== '0) begin
            bad++;
            $display("FAIL reset8: got busy=%b vld=%b last=%b done=%b ok=%b d=%h want 0",
                     o8_busy, o8_dvld, o8_dlast, o8_done, o8_ok, o8_dout);
        end
        total++;
        if ({o4_busy, o4_dvld, o4_dlast, o4_done, o4_ok, o4_dout} !== '0) begin
            bad++;
            $display("FAIL reset4: got busy=%b vld=%b last=%b done=%b ok=%b d=%h want 0",
                     o4_busy, o4_dvld, o4_dlast, o4_done, o4_ok, o4_dout);
        end
        total++;
        if (o8_crc !== 32'h0) begin
            bad++;
            $display("FAIL reset8 crc: got %h want 00000000", o8_crc);
        end
        #2;
        res = 1'b1;
        step();
    endtask

    task automatic test_known8();
        load_check_string();
        feed8(1'b0);
        total++;
        if (o8_done !== 1'b1 || o8_crc !== 32'hCBF43926 || o8_ok !== 1'b0) begin
            bad++;
            $display("FAIL known8: got done=%b crc=%h ok=%b want 1 cbf43926 0",
                     o8_done, o8_crc, o8_ok);
        end
        step();
        total++;
        if (o8_done !== 1'b0) begin
            bad++;
            $display("FAIL known8 pulse: got done=%b want 0", o8_done);
        end
        emit8(32'hCBF43926);
    endtask

    task automatic test_known4();
        load_check_string();
        feed4(1'b0);
        total++;
        if (o4_done !== 1'b1 || o4_crc !== 32'hCBF43926) begin
            bad++;
            $display("FAIL known4: got done=%b crc=%h want 1 cbf43926",
                     o4_done, o4_crc);
        end
        step();
        total++;
        if (o4_done !== 1'b0) begin
            bad++;
            $display("FAIL known4 pulse: got done=%b want 0", o4_done);
        end
        emit4(32'hCBF43926);
    endtask

    task automatic test_ignore();
        logic [31:0] exp;
        s8_fcs = 1'b1;
        step();
        s8_fcs = 1'b0;
        total++;
        if (o8_busy !== 1'b0 || o8_dvld !== 1'b0) begin
            bad++;
            $display("FAIL idle fcs: got busy=%b vld=%b want 0 0", o8_busy, o8_dvld);
        end
        fr.delete();
        fr.push_back(8'h5A);
        fr.push_back(8'hC3);
        s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        s8_vld = 1'b1;
        s8_din = fr[0];
        s8_fcs = 1'b1;
        step();
        s8_fcs = 1'b0;
        total++;
        if (o8_dvld !== 1'b0 || o8_busy !== 1'b1) begin
            bad++;
            $display("FAIL vld over fcs: got vld=%b busy=%b want 0 1", o8_dvld, o8_busy);
        end
        s8_din  = fr[1];
        s8_last = 1'b1;
        step();
        exp = ~model_r();
        total++;
        if (o8_done !== 1'b1 || o8_crc !== exp) begin
            bad++;
            $display("FAIL vld over fcs crc: got done=%b crc=%h want 1 %h",
                     o8_done, o8_crc, exp);
        end
        s8_din = 8'hFF;
        step();
        s8_vld  = 1'b0;
        s8_last = 1'b0;
        total++;
        if (o8_crc !== exp || o8_done !== 1'b0 || o8_busy !== 1'b1) begin
            bad++;
            $display("FAIL done ignores vld: got crc=%h done=%b busy=%b want %h 0 1",
                     o8_crc, o8_done, o8_busy, exp);
        end
        emit8(exp);
    endtask

    task automatic test_residue();
        load_check_string();
        fr.push_back(8'h26);
        fr.push_back(8'h39);
        fr.push_back(8'hF4);
        fr.push_back(8'hCB);
        feed8(1'b0);
        total++;
        if (o8_ok !== 1'b1 || o8_crc !== 32'h2144DF1C) begin
            bad++;
            $display("FAIL residue good: got ok=%b crc=%h want 1 2144df1c",
                     o8_ok, o8_crc);
        end
        repeat (3) step();
        total++;
        if (o8_ok !== 1'b1) begin
            bad++;
            $display("FAIL residue hold: got ok=%b want 1", o8_ok);
        end
        s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        total++;
        if (o8_ok !== 1'b0) begin
            bad++;
            $display("FAIL residue clear: got ok=%b want 0", o8_ok);
        end
        fr[3] = fr[3] ^ 8'h10;
        feed8(1'b0);
        total++;
        if (o8_ok !== 1'b0 || o8_done !== 1'b1) begin
            bad++;
            $display("FAIL residue bad: got ok=%b done=%b want 0 1", o8_ok, o8_done);
        end
    endtask

    task automatic test_start_mid_emit();
        logic [31:0] exp;
        load_check_string();
        feed8(1'b0);
        s8_fcs = 1'b1;
        step();
        s8_fcs = 1'b0;
        step();
        total++;
        if (o8_dvld !== 1'b1 || o8_dout !== 8'h39) begin
            bad++;
            $display("FAIL emit2: got vld=%b d=%h want 1 39", o8_dvld, o8_dout);
        end
        s8_start = 1'b1;
        step();
        s8_start = 1'b0;
        total++;
        if (o8_dvld !== 1'b0 || o8_busy !== 1'b1 || o8_crc !== 32'h0) begin
            bad++;
            $display("FAIL start mid emit: got vld=%b busy=%b crc=%h want 0 1 0",
                     o8_dvld, o8_busy, o8_crc);
        end
        fr.delete();
        fr.push_back(8'hA5);
        s8_vld  = 1'b1;
        s8_din  = 8'hA5;
        s8_last = 1'b1;
        step();
        s8_vld  = 1'b0;
        s8_last = 1'b0;
        exp = ~model_r();
        total++;
        if (o8_done !== 1'b1 || o8_crc !== exp) begin
            bad++;
            $display("FAIL after restart: got done=%b crc=%h want 1 %h",
                     o8_done, o8_crc, exp);
        end
        emit8(exp);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] exp;
        logic        good;
        for (int it = 0; it < 20; it++) begin
            fr.delete();
            repeat ($urandom_range(1, 16)) fr.push_back(8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                r = ~model_r();
                for (int k = 0; k < 4; k++) fr.push_back(r[8*k +: 8]);
            end
            r    = model_r();
            exp  = ~r;
            good = (r == 32'hDEBB20E3);
            feed8(1'b1);
            total++;
            if (o8_done !== 1'b1 || o8_crc !== exp || o8_ok !== good) begin
                bad++;
                $display("FAIL rand8 %0d: got done=%b crc=%h ok=%b want 1 %h %b",
                         it, o8_done, o8_crc, o8_ok, exp, good);
            end
            emit8(exp);
            feed4(1'b1);
            total++;
            if (o4_done !== 1'b1 || o4_crc !== exp || o4_ok !== good) begin
                bad++;
                $display("FAIL rand4 %0d: got done=%b crc=%h ok=%b want 1 %h %b",
                         it, o4_done, o4_crc, o4_ok, exp, good);
            end
            emit4(exp);
        end
    endtask

    task automatic test_reset_mid_emit();
        load_check_string();
        fr.push_back(8'h26);
        fr.push_back(8'h39);
        fr.push_back(8'hF4);
        fr.push_back(8'hCB);
        feed8(1'b0);
        s8_fcs = 1'b1;
        step();
        s8_fcs = 1'b0;
        step();
        total++;
        if (o8_dvld !== 1'b1 || o8_ok !== 1'b1 || o8_busy !== 1'b1) begin
            bad++;
            $display("FAIL pre reset: got vld=%b ok=%b busy=%b want 1 1 1",
                     o8_dvld, o8_ok, o8_busy);
        end
        #2;
        res = 1'b0;
        #1;
        total++;
        if ({o8_busy, o8_dvld, o8_dlast, o8_done, o8_ok, o8_dout} !== '0) begin
            bad++;
            $display("FAIL async reset: got busy=%b vld=%b last=%b done=%b ok=%b d=%h want 0",
                     o8_busy, o8_dvld, o8_dlast, o8_done, o8_ok, o8_dout);
        end
        #3;
        res = 1'b1;
        step();
        total++;
        if (o8_busy !== 1'b0 || o8_crc !== 32'h0) begin
            bad++;
            $display("FAIL post reset: got busy=%b crc=%h want 0 0", o8_busy, o8_crc);
        end
    endtask

    initial begin
        test_reset();
        test_known8();
        test_known4();
        test_ignore();
        test_residue();
        test_start_mid_emit();
        test_random();
        test_reset_mid_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 SHALL have parameter DW, default 4, meaning data path width in bits; legal values 4 and 8 only.
REQ-002 SHALL have parameter POLY, default 32'h04C11DB7, meaning the CRC-32 generator polynomial in MSB-first form.
REQ-003 SHALL have parameter INIT, default 32'hFFFFFFFF, meaning the CRC register preset value.
REQ-004 SHALL have parameter REFIN, default 1, meaning when 1 each din word is bit-reversed before the update.
REQ-005 SHALL have parameter REFOUT, default 1, meaning when 1 the crc output is the bit-reversed register.
REQ-006 SHALL have parameter XOROUT, default 32'hFFFFFFFF, meaning the value XORed onto the crc output.
REQ-007 SHALL have parameter RESIDUE, default 32'hC704DD7B, meaning the register value that indicates a good frame.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge triggered.
REQ-009 SHALL have port res, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port start, input, 1 bit: preset the register and begin a frame.
REQ-011 SHALL have port din_vld, input, 1 bit: din is valid this cycle.
REQ-012 SHALL have port din, input, DW bits: data word.
REQ-013 SHALL have port din_last, input, 1 bit: qualified by din_vld; marks the final data word.
REQ-014 SHALL have port fcs_req, input, 1 bit: begin serialising the FCS.
REQ-015 SHALL have port dout, output, DW bits: FCS word.
REQ-016 SHALL have port dout_vld, output, 1 bit: dout is valid.
REQ-017 SHALL have port dout_last, output, 1 bit: final FCS word.
REQ-018 SHALL have port crc, output, 32 bits: XOROUT ^ (REFOUT ? bitrev32(reg) : reg), combinational from the register.
REQ-019 SHALL have port crc_done, output, 1 bit: one-cycle pulse after din_last is accepted.
REQ-020 SHALL have port crc_ok, output, 1 bit: reg == RESIDUE, sampled at crc_done.
REQ-021 SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-022 SHALL implement the states IDLE, ACC, DONE and EMIT, with a 32-bit register reg and a 32/DW-cycle EMIT counter.
REQ-023 SHALL, on start in any state, set reg=INIT, go to ACC, clear crc_ok and clear the counter; start has highest priority and discards any same-cycle din_vld or fcs_req.
REQ-024 SHALL, in ACC with din_vld, set reg to the MSB-first DW-bit CRC update of reg with w, where w = REFIN ? bitrev(din) : din; the update is single-cycle, with new reg visible the next cycle.
REQ-025 SHALL, on din_vld&din_last in ACC, perform the update, go to DONE, pulse crc_done the next cycle, and set crc_ok = (updated reg == RESIDUE); crc_ok holds until the next start.
REQ-026 SHALL, on fcs_req in ACC (without din_vld) or in DONE, go to EMIT; in ACC, din_vld takes priority and fcs_req is ignored that cycle.
REQ-027 SHALL ignore fcs_req in IDLE and EMIT, and ignore din_vld in IDLE, DONE and EMIT.
REQ-028 SHALL, in EMIT, each cycle drive dout = bitrev_DW(~reg[31:32-DW]) (no reversal when REFIN=0) with dout_vld=1, then set reg={reg[31-DW:0], {DW{1'b1}}}.
REQ-029 SHALL assert dout_last with the 32/DW-th EMIT word, then go to IDLE; reg is not preset by the EMIT exit.
REQ-030 SHALL hold reg=INIT in IDLE and keep dout, dout_vld and dout_last at 0 outside EMIT.

Reset
REQ-031 SHALL, while res=0, force state=IDLE, reg=INIT, counter=0, and dout, dout_vld, dout_last, crc_done, crc_ok and busy all 0, taking effect asynchronously at any time, including mid-EMIT.
REQ-032 SHALL, on res release, process no input until the first rising clk edge, and SHALL require start before any frame.

Verification
REQ-033 SHALL cover DW=8: start, then ASCII "123456789" with last on '9' -> crc=32'hCBF43926 at crc_done.
REQ-034 SHALL cover DW=4: the same bytes fed low nibble first -> crc=32'hCBF43926, with the same crc_done timing.
REQ-035 SHALL cover DW=8: fcs_req after REQ-033 -> dout 8'h26, 8'h39, 8'hF4, 8'hCB on 4 consecutive cycles, dout_last on 8'hCB, then busy=0.
REQ-036 SHALL cover check mode: "123456789" followed by 26 39 F4 CB with last on CB -> reg=RESIDUE, crc_ok=1; flipping one payload bit -> crc_ok=0.
REQ-037 SHALL cover start asserted on the 2nd EMIT cycle -> dout_vld=0 next cycle, reg=INIT, state ACC.
REQ-038 SHALL cover res pulled low mid-EMIT -> all outputs 0 immediately, with no clk edge required.
